// File: rtl/self_attention_pkg.sv
// Shared constants, types and helpers for the self-attention datapath blocks.
// The bridge write-back block and its address generator import this package.
package self_attention_pkg;

   localparam int LANE_WIDTH    = 64;
   localparam int TOTAL_INPUT_W = 8;

   typedef logic [LANE_WIDTH-1:0] lane_t;

   typedef enum logic {WB_IDLE, WB_DRAIN} wb_state_t;

   // Two lanes leave per cycle (one per BRAM port), so an odd lane count needs one extra beat.
   function automatic int nbeat(input int lanes);
      return (lanes + 1) / 2;
   endfunction

endpackage

// File: rtl/bridge_bram_writeback_if.sv
// Vector-in / dual-port-BRAM-out bundle for bridge_bram_writeback.
// Optional BRIDGE_WB_OVERFLOW_EN adds overflow_err and drop_cnt.
interface bridge_bram_writeback_if #(
   parameter int LANE_WIDTH = 64,
   parameter int NUM_LANES  = 8,
   parameter int ADDR_WIDTH = 6
);

   logic                  in_valid;
   logic [LANE_WIDTH-1:0] in_data [NUM_LANES];
   logic                  in_ready;
   logic                  ena;
   logic                  wea;
   logic [ADDR_WIDTH-1:0] addra;
   logic [LANE_WIDTH-1:0] dina;
   logic                  enb;
   logic                  web;
   logic [ADDR_WIDTH-1:0] addrb;
   logic [LANE_WIDTH-1:0] dinb;
   logic                  frame_done;
`ifdef BRIDGE_WB_OVERFLOW_EN
   logic                  overflow_err;
   logic [15:0]           drop_cnt;

   modport master (
      output in_valid, in_data,
      input  in_ready, ena, wea, addra, dina, enb, web, addrb, dinb, frame_done,
      input  overflow_err, drop_cnt
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, ena, wea, addra, dina, enb, web, addrb, dinb, frame_done,
      output overflow_err, drop_cnt
   );
`else
   modport master (
      output in_valid, in_data,
      input  in_ready, ena, wea, addra, dina, enb, web, addrb, dinb, frame_done
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, ena, wea, addra, dina, enb, web, addrb, dinb, frame_done
   );
`endif

endinterface

// File: rtl/bridge_wb_addr_gen.sv
// Write pointer, beat counter and frame wrap tracking for bridge_bram_writeback.
// frame_done is registered so it pulses the cycle after the frame's last write.
module bridge_wb_addr_gen
   import self_attention_pkg::*;
#(
   parameter int NUM_LANES  = 8,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = 6,
   parameter int BEAT_W     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  draining,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic [BEAT_W-1:0]     beat,
   output logic                  last_beat,
   output logic                  frame_done
);

   localparam int                    NBEAT    = nbeat(NUM_LANES);
   localparam logic [BEAT_W-1:0]     LAST     = BEAT_W'(NBEAT - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(NUM_LANES);
   // Pointers only ever hold multiples of NUM_LANES, so this equality is the frame-end test.
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - NUM_LANES);

   logic wrap;

   assign last_beat = draining && (beat == LAST);
   assign wrap      = (wr_ptr == LAST_PTR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         beat       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= last_beat && wrap;
         if (last_beat) begin
            beat   <= '0;
            wr_ptr <= wrap ? '0 : wr_ptr + STEP;
         end else if (draining) begin
            beat <= beat + BEAT_W'(1);
         end else begin
            beat <= '0;
         end
      end
   end

endmodule

// File: rtl/bridge_bram_writeback.sv
// Drains captured multi-lane vectors into a true-dual-port BRAM, two lanes per cycle.
// Define BRIDGE_WB_OVERFLOW_EN to add the sticky overflow_err flag and saturating drop_cnt.
module bridge_bram_writeback
   import self_attention_pkg::*;
#(
   parameter int LANE_WIDTH = self_attention_pkg::LANE_WIDTH,
   parameter int NUM_LANES  = self_attention_pkg::TOTAL_INPUT_W,
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   bridge_bram_writeback_if.slave  bus
);

   localparam int NBEAT  = nbeat(NUM_LANES);
   localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam int LIDX_W = $clog2(NUM_LANES);
   localparam bit ODD    = (NUM_LANES % 2) == 1;

   wb_state_t             state;
   wb_state_t             state_next;
   logic [LANE_WIDTH-1:0] hold_p0 [NUM_LANES];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] base;
   logic [BEAT_W-1:0]     beat;
   logic [LIDX_W-1:0]     lane_a;
   logic [LIDX_W-1:0]     lane_b;
   logic                  last_beat;
   logic                  frame_done;
   logic                  ready;
   logic                  capture;

   // Gated by rst_n so every output reads 0 while reset is held.
   assign ready        = rst_n && ((state == WB_IDLE) || last_beat);
   assign capture      = bus.in_valid && ready;
   assign bus.in_ready = ready;
   assign bus.frame_done = frame_done;

   bridge_wb_addr_gen #(
      .NUM_LANES  (NUM_LANES),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BEAT_W     (BEAT_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .draining   (state == WB_DRAIN),
      .wr_ptr     (wr_ptr),
      .beat       (beat),
      .last_beat  (last_beat),
      .frame_done (frame_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WB_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         WB_IDLE:  if (capture) state_next = WB_DRAIN;
         WB_DRAIN: if (last_beat) state_next = capture ? WB_DRAIN : WB_IDLE;
         default:  state_next = WB_IDLE;
      endcase
   end

   // Stage p0: holding register, written only when a vector is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++) hold_p0[i] <= '0;
      end else if (capture) begin
         for (int i = 0; i < NUM_LANES; i++) hold_p0[i] <= bus.in_data[i];
      end
   end

   assign lane_a = LIDX_W'({beat, 1'b0});
   assign lane_b = LIDX_W'({beat, 1'b1});
   assign base   = wr_ptr + ADDR_WIDTH'({beat, 1'b0});

   // Stage p1: port muxing, driven purely from registered state
   always_comb begin
      bus.ena   = 1'b0;
      bus.wea   = 1'b0;
      bus.addra = '0;
      bus.dina  = '0;
      bus.enb   = 1'b0;
      bus.web   = 1'b0;
      bus.addrb = '0;
      bus.dinb  = '0;
      if (state == WB_DRAIN) begin
         bus.ena   = 1'b1;
         bus.wea   = 1'b1;
         bus.addra = base;
         bus.dina  = hold_p0[lane_a];
         if (!(ODD && last_beat)) begin
            bus.enb   = 1'b1;
            bus.web   = 1'b1;
            bus.addrb = base + ADDR_WIDTH'(1);
            bus.dinb  = hold_p0[lane_b];
         end
      end
   end

`ifdef BRIDGE_WB_OVERFLOW_EN
   logic        drop;
   logic        overflow_err_q;
   logic [15:0] drop_cnt_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign drop = bus.in_valid && !ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_err_q <= 1'b0;
         drop_cnt_q     <= '0;
      end else if (drop) begin
         overflow_err_q <= 1'b1;
         drop_cnt_q     <= sat_inc(drop_cnt_q);
      end
   end

   assign bus.overflow_err = overflow_err_q;
   assign bus.drop_cnt     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_bridge_bram_writeback.sv
// Directed bench for bridge_bram_writeback: 4-lane/depth-8 and 3-lane/depth-6 instances.
// Overflow checks are compiled in when BRIDGE_WB_OVERFLOW_EN is defined.
module tb_bridge_bram_writeback;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   bridge_bram_writeback_if #(.LANE_WIDTH(16), .NUM_LANES(4), .ADDR_WIDTH(3)) bus4 ();
   bridge_bram_writeback_if #(.LANE_WIDTH(16), .NUM_LANES(3), .ADDR_WIDTH(3)) bus3 ();

   bridge_bram_writeback #(.LANE_WIDTH(16), .NUM_LANES(4), .DEPTH(8), .ADDR_WIDTH(3)) u4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   bridge_bram_writeback #(.LANE_WIDTH(16), .NUM_LANES(3), .DEPTH(6), .ADDR_WIDTH(3)) u3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load4(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
      bus4.in_data[0] = a;
      bus4.in_data[1] = b;
      bus4.in_data[2] = c;
      bus4.in_data[3] = d;
   endtask

   task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      bus3.in_data[0] = a;
      bus3.in_data[1] = b;
      bus3.in_data[2] = c;
   endtask

   task automatic do_reset();
      bus4.in_valid = 1'b0;
      bus3.in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if ({bus4.ena, bus4.wea, bus4.enb, bus4.web, bus4.in_ready, bus4.frame_done} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctl4 got=%b want=000000",
                  {bus4.ena, bus4.wea, bus4.enb, bus4.web, bus4.in_ready, bus4.frame_done});
      end
      total++;
      if ({bus4.addra, bus4.dina, bus4.addrb, bus4.dinb} !== 38'b0) begin
         bad++;
         $display("FAIL reset_data4 got=%h want=0", {bus4.addra, bus4.dina, bus4.addrb, bus4.dinb});
      end
      total++;
      if ({bus3.ena, bus3.wea, bus3.enb, bus3.web, bus3.in_ready, bus3.frame_done} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctl3 got=%b want=000000",
                  {bus3.ena, bus3.wea, bus3.enb, bus3.web, bus3.in_ready, bus3.frame_done});
      end
`ifdef BRIDGE_WB_OVERFLOW_EN
      total++;
      if ({bus4.overflow_err, bus4.drop_cnt} !== 17'b0) begin
         bad++;
         $display("FAIL reset_ovf got=%h want=0", {bus4.overflow_err, bus4.drop_cnt});
      end
`endif
      rst_n = 1'b1;
      #1;
      total++;
      if ({bus4.in_ready, bus3.in_ready} !== 2'b11) begin
         bad++;
         $display("FAIL reset_release_ready got=%b want=11", {bus4.in_ready, bus3.in_ready});
      end
      tick();
   endtask

   task automatic test_single();
      load4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      bus4.in_valid = 1'b1;
      total++;
      if (bus4.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_ready_idle got=%b want=1", bus4.in_ready);
      end
      tick();
      bus4.in_valid = 1'b0;
      total++;
      if ({bus4.ena, bus4.wea, bus4.addra, bus4.dina} !== {2'b11, 3'd0, 16'h1111}) begin
         bad++;
         $display("FAIL single_beat0_a got=%h want=%h",
                  {bus4.ena, bus4.wea, bus4.addra, bus4.dina}, {2'b11, 3'd0, 16'h1111});
      end
      total++;
      if ({bus4.enb, bus4.web, bus4.addrb, bus4.dinb} !== {2'b11, 3'd1, 16'h2222}) begin
         bad++;
         $display("FAIL single_beat0_b got=%h want=%h",
                  {bus4.enb, bus4.web, bus4.addrb, bus4.dinb}, {2'b11, 3'd1, 16'h2222});
      end
      total++;
      if (bus4.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_ready_beat0 got=%b want=0", bus4.in_ready);
      end
      tick();
      total++;
      if ({bus4.ena, bus4.wea, bus4.addra, bus4.dina} !== {2'b11, 3'd2, 16'h3333}) begin
         bad++;
         $display("FAIL single_beat1_a got=%h want=%h",
                  {bus4.ena, bus4.wea, bus4.addra, bus4.dina}, {2'b11, 3'd2, 16'h3333});
      end
      total++;
      if ({bus4.enb, bus4.web, bus4.addrb, bus4.dinb} !== {2'b11, 3'd3, 16'h4444}) begin
         bad++;
         $display("FAIL single_beat1_b got=%h want=%h",
                  {bus4.enb, bus4.web, bus4.addrb, bus4.dinb}, {2'b11, 3'd3, 16'h4444});
      end
      total++;
      if (bus4.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL single_ready_last got=%b want=1", bus4.in_ready);
      end
      tick();
      total++;
      if ({bus4.ena, bus4.wea, bus4.enb, bus4.web, bus4.in_ready, bus4.frame_done} !== 6'b000010) begin
         bad++;
         $display("FAIL single_idle got=%b want=000010",
                  {bus4.ena, bus4.wea, bus4.enb, bus4.web, bus4.in_ready, bus4.frame_done});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      load4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
      bus4.in_valid = 1'b1;
      tick();
      load4(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
      total++;
      if ({bus4.in_ready, bus4.ena, bus4.addra, bus4.dina} !== {2'b01, 3'd0, 16'h1111}) begin
         bad++;
         $display("FAIL b2b_beat0_busy got=%h want=%h",
                  {bus4.in_ready, bus4.ena, bus4.addra, bus4.dina}, {2'b01, 3'd0, 16'h1111});
      end
      tick();
      load4(16'h0005, 16'h0006, 16'h0007, 16'h0008);
      total++;
      if ({bus4.in_ready, bus4.ena, bus4.addra, bus4.dina} !== {2'b11, 3'd2, 16'h3333}) begin
         bad++;
         $display("FAIL b2b_beat1_a got=%h want=%h",
                  {bus4.in_ready, bus4.ena, bus4.addra, bus4.dina}, {2'b11, 3'd2, 16'h3333});
      end
      total++;
      if ({bus4.enb, bus4.addrb, bus4.dinb} !== {1'b1, 3'd3, 16'h4444}) begin
         bad++;
         $display("FAIL b2b_hold_kept got=%h want=%h",
                  {bus4.enb, bus4.addrb, bus4.dinb}, {1'b1, 3'd3, 16'h4444});
      end
      tick();
      bus4.in_valid = 1'b0;
      total++;
      if ({bus4.frame_done, bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb} !==
          {2'b01, 3'd4, 16'h0005, 1'b1, 3'd5, 16'h0006}) begin
         bad++;
         $display("FAIL b2b_v2_beat0 got=%h want=%h",
                  {bus4.frame_done, bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb},
                  {2'b01, 3'd4, 16'h0005, 1'b1, 3'd5, 16'h0006});
      end
      tick();
      total++;
      if ({bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb} !==
          {1'b1, 3'd6, 16'h0007, 1'b1, 3'd7, 16'h0008}) begin
         bad++;
         $display("FAIL b2b_v2_beat1 got=%h want=%h",
                  {bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb},
                  {1'b1, 3'd6, 16'h0007, 1'b1, 3'd7, 16'h0008});
      end
      load4(16'h0009, 16'h000A, 16'h000B, 16'h000C);
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      total++;
      if (bus4.frame_done !== 1'b1) begin
         bad++;
         $display("FAIL b2b_frame_done got=%b want=1", bus4.frame_done);
      end
      total++;
      if ({bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb} !==
          {1'b1, 3'd0, 16'h0009, 1'b1, 3'd1, 16'h000A}) begin
         bad++;
         $display("FAIL b2b_wrap_beat0 got=%h want=%h",
                  {bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb},
                  {1'b1, 3'd0, 16'h0009, 1'b1, 3'd1, 16'h000A});
      end
      tick();
      total++;
      if ({bus4.frame_done, bus4.addra, bus4.dina, bus4.addrb, bus4.dinb} !==
          {1'b0, 3'd2, 16'h000B, 3'd3, 16'h000C}) begin
         bad++;
         $display("FAIL b2b_wrap_beat1 got=%h want=%h",
                  {bus4.frame_done, bus4.addra, bus4.dina, bus4.addrb, bus4.dinb},
                  {1'b0, 3'd2, 16'h000B, 3'd3, 16'h000C});
      end
      tick();
      total++;
      if ({bus4.ena, bus4.enb, bus4.frame_done} !== 3'b000) begin
         bad++;
         $display("FAIL b2b_idle got=%b want=000", {bus4.ena, bus4.enb, bus4.frame_done});
      end
`ifdef BRIDGE_WB_OVERFLOW_EN
      total++;
      if ({bus4.overflow_err, bus4.drop_cnt} !== {1'b1, 16'd1}) begin
         bad++;
         $display("FAIL b2b_overflow got=%h want=%h", {bus4.overflow_err, bus4.drop_cnt}, {1'b1, 16'd1});
      end
`endif
   endtask

   task automatic test_odd_lanes();
      load3(16'h000A, 16'h000B, 16'h000C);
      bus3.in_valid = 1'b1;
      tick();
      bus3.in_valid = 1'b0;
      total++;
      if ({bus3.ena, bus3.wea, bus3.addra, bus3.dina, bus3.enb, bus3.web, bus3.addrb, bus3.dinb} !==
          {2'b11, 3'd0, 16'h000A, 2'b11, 3'd1, 16'h000B}) begin
         bad++;
         $display("FAIL odd_beat0 got=%h want=%h",
                  {bus3.ena, bus3.wea, bus3.addra, bus3.dina, bus3.enb, bus3.web, bus3.addrb, bus3.dinb},
                  {2'b11, 3'd0, 16'h000A, 2'b11, 3'd1, 16'h000B});
      end
      tick();
      total++;
      if ({bus3.ena, bus3.wea, bus3.addra, bus3.dina} !== {2'b11, 3'd2, 16'h000C}) begin
         bad++;
         $display("FAIL odd_last_a got=%h want=%h",
                  {bus3.ena, bus3.wea, bus3.addra, bus3.dina}, {2'b11, 3'd2, 16'h000C});
      end
      total++;
      if ({bus3.enb, bus3.web, bus3.addrb, bus3.dinb, bus3.in_ready} !== {2'b00, 3'd0, 16'h0000, 1'b1}) begin
         bad++;
         $display("FAIL odd_last_b_off got=%h want=%h",
                  {bus3.enb, bus3.web, bus3.addrb, bus3.dinb, bus3.in_ready}, {2'b00, 3'd0, 16'h0000, 1'b1});
      end
      tick();
      load3(16'h000D, 16'h000E, 16'h000F);
      bus3.in_valid = 1'b1;
      tick();
      bus3.in_valid = 1'b0;
      total++;
      if ({bus3.addra, bus3.dina, bus3.addrb, bus3.dinb} !== {3'd3, 16'h000D, 3'd4, 16'h000E}) begin
         bad++;
         $display("FAIL odd_v2_beat0 got=%h want=%h",
                  {bus3.addra, bus3.dina, bus3.addrb, bus3.dinb}, {3'd3, 16'h000D, 3'd4, 16'h000E});
      end
      tick();
      total++;
      if ({bus3.ena, bus3.addra, bus3.dina, bus3.enb} !== {1'b1, 3'd5, 16'h000F, 1'b0}) begin
         bad++;
         $display("FAIL odd_v2_beat1 got=%h want=%h",
                  {bus3.ena, bus3.addra, bus3.dina, bus3.enb}, {1'b1, 3'd5, 16'h000F, 1'b0});
      end
      tick();
      total++;
      if ({bus3.frame_done, bus3.ena} !== 2'b10) begin
         bad++;
         $display("FAIL odd_frame_done got=%b want=10", {bus3.frame_done, bus3.ena});
      end
      tick();
      total++;
      if (bus3.frame_done !== 1'b0) begin
         bad++;
         $display("FAIL odd_frame_done_pulse got=%b want=0", bus3.frame_done);
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
`ifdef BRIDGE_WB_OVERFLOW_EN
      total++;
      if (bus4.overflow_err !== 1'b0) begin
         bad++;
         $display("FAIL mid_ovf_cleared got=%b want=0", bus4.overflow_err);
      end
`endif
      load4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      tick();
      tick();
      load4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      total++;
      if ({bus4.ena, bus4.addra, bus4.dina} !== {1'b1, 3'd4, 16'h0010}) begin
         bad++;
         $display("FAIL mid_pre_reset got=%h want=%h", {bus4.ena, bus4.addra, bus4.dina}, {1'b1, 3'd4, 16'h0010});
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus4.ena, bus4.wea, bus4.enb, bus4.web, bus4.in_ready} !== 5'b0) begin
         bad++;
         $display("FAIL mid_async_drop got=%b want=00000",
                  {bus4.ena, bus4.wea, bus4.enb, bus4.web, bus4.in_ready});
      end
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if ({bus4.ena, bus4.enb, bus4.in_ready} !== 3'b001) begin
         bad++;
         $display("FAIL mid_no_writes got=%b want=001", {bus4.ena, bus4.enb, bus4.in_ready});
      end
      load4(16'h0050, 16'h0060, 16'h0070, 16'h0080);
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      total++;
      if ({bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb} !==
          {1'b1, 3'd0, 16'h0050, 1'b1, 3'd1, 16'h0060}) begin
         bad++;
         $display("FAIL mid_restart_addr got=%h want=%h",
                  {bus4.ena, bus4.addra, bus4.dina, bus4.enb, bus4.addrb, bus4.dinb},
                  {1'b1, 3'd0, 16'h0050, 1'b1, 3'd1, 16'h0060});
      end
      tick();
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus4.in_valid = 1'b0;
      bus3.in_valid = 1'b0;
      load4(16'h0, 16'h0, 16'h0, 16'h0);
      load3(16'h0, 16'h0, 16'h0);
      test_reset();
      test_single();
      test_back_to_back();
      test_odd_lanes();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bridge_bram_writeback.md
Name: bridge_bram_writeback

Overview:
- Write-side counterpart of the bridge/right-shift path.
- Accepts one shifted multi-lane vector per out_valid_shifted pulse (NUM_LANES lanes, each LANE_WIDTH bits).
- Drains each vector into a true-dual-port BRAM: even lanes on port A, odd lanes on port B, two words per cycle, at consecutive addresses.
- Sits between top_bridge_rshift output and the result/score BRAM feeding the next self-attention stage.

Parameters:
- LANE_WIDTH, 64, bits per lane; equals WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A_Qn_KnT*NUM_CORES_B_Qn_KnT*TOTAL_MODULES_LP_Q.
- NUM_LANES, 8, lanes per vector; equals TOTAL_INPUT_W; must be ≥2.
- DEPTH, 64, BRAM words per frame; must be a multiple of NUM_LANES.
- ADDR_WIDTH, $clog2(DEPTH), BRAM address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  vector strobe (from out_valid_shifted), single-cycle pulse
- in_data  in  LANE_WIDTH x NUM_LANES (unpacked array)  shifted vector (from out_bridge_shifted)
- in_ready  out  1  high when a vector presented this cycle will be captured
- bram_ena / bram_wea  out  1 / 1  port A enable / write enable
- bram_addra  out  ADDR_WIDTH  port A address (even)
- bram_dina  out  LANE_WIDTH  port A data
- bram_enb / bram_web  out  1 / 1  port B enable / write enable
- bram_addrb  out  ADDR_WIDTH  port B address (odd)
- bram_dinb  out  LANE_WIDTH  port B data
- frame_done  out  1  one-cycle pulse after the last word of a frame is written

Behaviour:
- Reset: all outputs 0; FSM to IDLE; wr_ptr=0; lane index=0; holding register cleared. Reset mid-drain aborts the vector; no further writes are issued.
- FSM states: IDLE and DRAIN.
  - IDLE: in_ready=1. If in_valid, capture all lanes into the holding register and go to DRAIN.
  - DRAIN: one cycle per lane pair; NBEAT = ceil(NUM_LANES/2) cycles.
  - On the last beat: in_ready=1. If in_valid is high, recapture and stay in DRAIN (seamless back-to-back). Otherwise return to IDLE.
  - On non-last beats: in_ready=0.
- Beat k (0-based), registered outputs:
  - Port A: ena=wea=1, addra=wr_ptr+2k, dina=lane[2k].
  - Port B: enb=web=1, addrb=wr_ptr+2k+1, dinb=lane[2k+1].
  - If NUM_LANES is odd, on the last beat port B has enb=web=0 and addrb/dinb=0; the last word is not duplicated.
- Latency: first write appears the cycle after the capturing in_valid edge. Ports idle (en=we=0) whenever not writing.
- Pointer:
  - After the last beat, wr_ptr += NUM_LANES.
  - When wr_ptr+NUM_LANES == DEPTH, wr_ptr wraps to 0 and frame_done pulses in the cycle following the last write.
  - Address arithmetic is ADDR_WIDTH bits, unsigned; no carry beyond DEPTH by construction.
- Boundary conditions:
  - in_valid while in_ready=0: the vector is dropped and the holding register is unchanged; the current drain is unaffected.
  - in_valid on the last beat of the last vector of a frame: accepted; new frame starts at address 0 and frame_done still pulses.
  - Holding register updates only on capture.

Optional Feature:
- Macro BRIDGE_WB_OVERFLOW_EN.
- Defined:
  - Extra output port overflow_err (1 bit) and a drop counter drop_cnt (16 bits, saturating).
  - overflow_err is sticky and set on any in_valid while in_ready=0; it is cleared only by rst_n.
  - drop_cnt increments per dropped vector.
- Undefined: ports absent; drops are silent.

Decomposition:
- Shared package self_attention_pkg holds:
  - LANE_WIDTH and NUM_LANES (as TOTAL_INPUT_W) constants.
  - typedef lane_t (logic [LANE_WIDTH-1:0]).
  - typedef wb_state_t enum {WB_IDLE, WB_DRAIN}.
  - NBEAT localparam function.
- One sub-module is natural: bridge_wb_addr_gen, containing wr_ptr, beat counter, last-beat and wrap detection, and frame_done generation.
- The top holds the FSM, holding register and port muxing.

Test Plan:
- Common configuration: NUM_LANES=4, LANE_WIDTH=16, DEPTH=8.
- Single vector {0x1111,0x2222,0x3333,0x4444}:
  - Cycle+1: A@0=0x1111, B@1=0x2222.
  - Cycle+2: A@2=0x3333, B@3=0x4444.
  - Then ena=enb=0, in_ready=1.
- Back-to-back frame: valid on both of the second vector's beats (0x5..0x8 shown only on its second beat):
  - On beat 0, in_ready=0 and the vector is dropped (overflow_err=1 when the macro is defined).
  - On beat 1, it is captured and written to addresses 4..7.
  - frame_done pulses once.
  - Next vector lands at address 0.
- Odd lanes, NUM_LANES=3, vector {0xA,0xB,0xC}:
  - Writes A@0=0xA, B@1=0xB, then A@2=0xC with enb=0.
  - Next vector starts at address 3.
- Reset asserted on the first drain beat:
  - All en/we drop to 0 asynchronously.
  - After release, the next vector writes at address 0.
- End-to-end with top_bridge_rshift: load mat_A_lp_bridge.mem through the input BRAM.
  - Readback of the written BRAM equals the golden shifted scores.
  - No drops occur (drop_cnt=0).
